// File: rtl/pm_pkg.sv
// ============================================================================
// pm_pkg : shared types and helpers for the pseudo-Mersenne multiplier
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FINAL = 2'd3
    } pm_state_t;

    localparam int P25519_N = 255;
    localparam int P25519_C = 19;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pm_fold.sv
// ============================================================================
// pm_fold : one pseudo-Mersenne fold, y = x[N-1:0] + x[IW-1:N] * C
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pm_fold #(
    parameter int IW = 260,
    parameter int N  = 255,
    parameter int C  = 19,
    parameter int OW = 256
) (
    input  logic [IW-1:0] x_i,
    output logic [OW-1:0] y_o
);

    localparam int HW = IW - N;
    localparam int CW = $clog2(C + 1);
    localparam int PW = HW + CW;

    logic [PW-1:0] hc_d;

    // High part times C stays narrow; only the final add spans the full width.
    assign hc_d = PW'(x_i[IW-1:N]) * PW'(C);
    assign y_o  = OW'(x_i[N-1:0]) + OW'(hc_d);

endmodule

`default_nettype wire

// File: rtl/pm_mult_seq.sv
// ============================================================================
// pm_mult_seq : digit-serial a*b mod (2^N - C), MSB-first shift-add with folds
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pm_mult_seq
    import pm_pkg::*;
#(
    parameter int N = P25519_N,
    parameter int C = P25519_C,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] prod
);

    localparam int           K     = ceil_div(N, D);
    localparam int           AW    = K * D;
    localparam int           TW    = N + D + 1;
    localparam int           CNTW  = (K > 1) ? $clog2(K) : 1;
    localparam logic [N-1:0] P_VAL = {N{1'b1}} - N'(C - 1);

    generate
        if (D < 1 || D > 16 || C <= 0 || $clog2(C + 1) > N - D - 2) begin : g_bad_params
            $error("pm_mult_seq: parameters violate 1<=D<=16 or 0<C<2^(N-D-2)");
        end
    endgenerate

    pm_state_t      state_q;
    logic [AW-1:0]  a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   acc_q;
    logic [CNTW-1:0] cnt_q;
    logic           ready_q;
    logic           done_q;
    logic [N-1:0]   prod_q;

    logic [D-1:0]   digit_d;
    logic [TW-1:0]  t_d;
    logic [N:0]     fold1_d;
    logic [N-1:0]   acc_d;
    logic [N-1:0]   b_red_d;
    logic [N-1:0]   prod_d;

    // a_q is shifted left each RUN cycle, so the current digit is always on top.
    assign digit_d = a_q[AW-1 -: D];
    assign t_d     = {1'b0, acc_q, {D{1'b0}}} + TW'(digit_d) * TW'(b_q);

    pm_fold #(.IW(TW), .N(N), .C(C), .OW(N + 1)) u_fold1 (
        .x_i (t_d),
        .y_o (fold1_d)
    );

    // After the second fold the result is provably below 2^N.
    pm_fold #(.IW(N + 1), .N(N), .C(C), .OW(N)) u_fold2 (
        .x_i (fold1_d),
        .y_o (acc_d)
    );

    assign b_red_d = (b_q >= P_VAL) ? (b_q - P_VAL) : b_q;
    assign prod_d  = (acc_q >= P_VAL) ? (acc_q - P_VAL) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= AW'(a);
                        b_q     <= b;
                        acc_q   <= '0;
                        state_q <= ST_LOAD;
                        ready_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        b_q     <= b_red_d;
                        cnt_q   <= CNTW'(K - 1);
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        a_q   <= a_q << D;
                        if (cnt_q == '0) begin
                            state_q <= ST_FINAL;
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                end
                ST_FINAL: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    if (!abort) begin
                        prod_q <= prod_d;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign prod  = prod_q;

endmodule

`default_nettype wire

// File: tb/tb_pm_mult_seq.sv
// ============================================================================
// tb_pm_mult_seq : randomized model-checked bench over D = 1, 4, 8, 16
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pm_mult_seq;

    localparam int           N     = 255;
    localparam int           C     = 19;
    localparam int           NI    = 4;
    localparam int           NRAND = 150;
    localparam int           DI    = 1;
    localparam logic [N-1:0] P     = {N{1'b1}} - N'(18);

    function automatic int d_of(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        return (N + d_of(i) - 1) / d_of(i) + 3;
    endfunction

    function automatic logic [N-1:0] modmul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N+1:0] w;
        w = (2*N+2)'(x) * (2*N+2)'(y);
        w = w % (2*N+2)'(P);
        return w[N-1:0];
    endfunction

    function automatic logic [N-1:0] rnd_op();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        case ($urandom_range(0, 9))
            0:       return P - N'(r[3:0]) - N'(1);
            1:       return {N{1'b1}} - N'(r[3:0]);
            2:       return N'(r[7:0]);
            default: return r[N-1:0];
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rstn_v  [NI] = '{default: 1'b0};
    logic         start_v [NI] = '{default: 1'b0};
    logic         abort_v [NI] = '{default: 1'b0};
    logic [N-1:0] a_v     [NI] = '{default: '0};
    logic [N-1:0] b_v     [NI] = '{default: '0};
    logic         ready_v [NI];
    logic         done_v  [NI];
    logic [N-1:0] prod_v  [NI];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (D=%0d): got %0h, want %0h", nm, d, act, exp);
    endtask

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int DG = d_of(gi);
        localparam int LG = lat_of(gi);

        pm_mult_seq #(.N(N), .C(C), .D(DG)) u_dut (
            .clk   (clk),
            .rst_n (rstn_v[gi]),
            .start (start_v[gi]),
            .abort (abort_v[gi]),
            .a     (a_v[gi]),
            .b     (b_v[gi]),
            .ready (ready_v[gi]),
            .done  (done_v[gi]),
            .prod  (prod_v[gi])
        );

        // Model: busy countdown from acceptance to the done cycle.
        logic         m_busy = 1'b0;
        logic         m_done = 1'b0;
        logic [N-1:0] m_val  = '0;
        logic [N-1:0] m_prod = '0;
        int           m_rem  = 0;

        always @(posedge clk or negedge rstn_v[gi]) begin
            if (!rstn_v[gi]) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
                m_prod <= '0;
                m_rem  <= 0;
            end else begin
                m_done <= 1'b0;
                if (!m_busy) begin
                    if (start_v[gi]) begin
                        m_busy <= 1'b1;
                        m_rem  <= LG - 1;
                        m_val  <= modmul(a_v[gi], b_v[gi]);
                    end
                end else if (abort_v[gi]) begin
                    m_busy <= 1'b0;
                end else if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_prod <= m_val;
                    m_done <= 1'b1;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end
        end

        always @(negedge clk) begin
            chk("ready", DG, N'(ready_v[gi]), N'(!m_busy));
            chk("done",  DG, N'(done_v[gi]),  N'(m_done));
            chk("prod",  DG, prod_v[gi],      m_prod);
        end
    end

    task automatic op_start(input int i, input logic [N-1:0] x, input logic [N-1:0] y);
        start_v[i] = 1'b1;
        a_v[i]     = x;
        b_v[i]     = y;
    endtask

    task automatic wait_done(input int i, input int pulse_at, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                a_v[i] = rnd_op();
                b_v[i] = rnd_op();
                chk("ready_busy", d_of(i), N'(ready_v[i]), N'(0));
            end
            start_v[i] = (lat == pulse_at);
        end while (!done_v[i] && lat < 400);
        start_v[i] = 1'b0;
    endtask

    task automatic directed(input int i);
        int lat;
        int nd;
        int d;
        d = d_of(i);
        @(posedge clk); #1;
        chk("rst_ready", d, N'(ready_v[i]), N'(1));
        chk("rst_done",  d, N'(done_v[i]),  N'(0));
        chk("rst_prod",  d, prod_v[i],      N'(0));

        op_start(i, N'(3), N'(5));
        wait_done(i, -1, lat);
        chk("lat_3x5",  d, N'(lat),   N'(67));
        chk("prod_3x5", d, prod_v[i], N'(15));

        op_start(i, P - N'(1), P - N'(1));
        wait_done(i, -1, lat);
        chk("lat_pm1",  d, N'(lat),   N'(67));
        chk("prod_pm1", d, prod_v[i], N'(1));

        op_start(i, {N{1'b1}}, N'(2));
        wait_done(i, -1, lat);
        chk("prod_max_x2", d, prod_v[i], N'(36));

        op_start(i, N'(1), P + N'(5));
        wait_done(i, -1, lat);
        chk("prod_b_ge_p", d, prod_v[i], N'(5));

        // done is high now: start again in the same cycle
        chk("b2b_done_now", d, N'(done_v[i]), N'(1));
        op_start(i, N'(7), N'(9));
        wait_done(i, -1, lat);
        chk("lat_b2b",  d, N'(lat),   N'(67));
        chk("prod_b2b", d, prod_v[i], N'(63));

        op_start(i, N'(11), N'(13));
        wait_done(i, 20, lat);
        chk("lat_pulse",  d, N'(lat),   N'(67));
        chk("prod_pulse", d, prod_v[i], N'(143));
        nd = 0;
        repeat (80) begin @(posedge clk); #1; if (done_v[i]) nd++; end
        chk("no_extra_done", d, N'(nd), N'(0));

        op_start(i, N'(2), N'(2));
        for (int c = 1; c <= 11; c++) begin @(posedge clk); #1; start_v[i] = 1'b0; end
        abort_v[i] = 1'b1;
        @(posedge clk); #1;
        abort_v[i] = 1'b0;
        chk("abort_ready", d, N'(ready_v[i]), N'(1));
        nd = 0;
        repeat (80) begin @(posedge clk); #1; if (done_v[i]) nd++; end
        chk("abort_no_done", d, N'(nd),   N'(0));
        chk("abort_prod",    d, prod_v[i], N'(143));

        op_start(i, N'(5), N'(5));
        for (int c = 1; c <= 20; c++) begin @(posedge clk); #1; start_v[i] = 1'b0; end
        #2;
        rstn_v[i] = 1'b0;
        #1;
        chk("arst_prod",  d, prod_v[i],       N'(0));
        chk("arst_ready", d, N'(ready_v[i]),  N'(1));
        chk("arst_done",  d, N'(done_v[i]),   N'(0));
        @(posedge clk); #1;
        rstn_v[i] = 1'b1;
        @(posedge clk); #1;

        op_start(i, N'(6), N'(7));
        wait_done(i, -1, lat);
        chk("lat_after_rst",  d, N'(lat),   N'(67));
        chk("prod_after_rst", d, prod_v[i], N'(42));
    endtask

    task automatic run_random(input int i, input int nops);
        int ops;
        int guard;
        ops   = 0;
        guard = 0;
        while (ops < nops && guard < 80000) begin
            @(posedge clk); #1;
            guard++;
            a_v[i]     = rnd_op();
            b_v[i]     = rnd_op();
            abort_v[i] = ($urandom_range(0, 1999) == 0);
            start_v[i] = ($urandom_range(0, 3) == 0);
            if (start_v[i] && ready_v[i]) ops++;
        end
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        abort_v[i] = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("random_ops", d_of(i), N'(ops), N'(nops));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rstn_v[k] = 1'b1;
        fork
            run_random(0, NRAND);
            begin
                directed(DI);
                run_random(DI, NRAND);
            end
            run_random(2, NRAND);
            run_random(3, NRAND);
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
